// File: rtl/id_ex_if.sv
// Bundle between the IF/ID register, the register file and the ID/EX pipeline stage.
interface id_ex_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      IF_ID_inst_i;
  logic [31:0]      IF_ID_pc_i;
  logic [31:0]      RSdata_i;
  logic [31:0]      RTdata_i;
  logic [31:0]      Imm32_i;
  logic             flush_i;
  logic             PCWrite_o;
  logic             IF_ID_Write_o;
  logic             ID_EX_RegWrite_o;
  logic             ID_EX_MemtoReg_o;
  logic             ID_EX_MemRead_o;
  logic             ID_EX_MemWrite_o;
  logic             ID_EX_ALUSrc_o;
  logic             ID_EX_RegDst_o;
  logic             ID_EX_Branch_o;
  logic [1:0]       ID_EX_ALUOp_o;
  logic [31:0]      ID_EX_pc_o;
  logic [31:0]      ID_EX_RSdata_o;
  logic [31:0]      ID_EX_RTdata_o;
  logic [31:0]      ID_EX_Imm_o;
  logic [4:0]       ID_EX_RSaddr_o;
  logic [4:0]       ID_EX_RTaddr_o;
  logic [4:0]       ID_EX_RDaddr_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport slave (
    input  IF_ID_inst_i, IF_ID_pc_i, RSdata_i, RTdata_i, Imm32_i, flush_i,
    output PCWrite_o, IF_ID_Write_o,
    output ID_EX_RegWrite_o, ID_EX_MemtoReg_o, ID_EX_MemRead_o, ID_EX_MemWrite_o,
    output ID_EX_ALUSrc_o, ID_EX_RegDst_o, ID_EX_Branch_o, ID_EX_ALUOp_o,
    output ID_EX_pc_o, ID_EX_RSdata_o, ID_EX_RTdata_o, ID_EX_Imm_o,
    output ID_EX_RSaddr_o, ID_EX_RTaddr_o, ID_EX_RDaddr_o, stall_cnt_o
  );

  modport master (
    output IF_ID_inst_i, IF_ID_pc_i, RSdata_i, RTdata_i, Imm32_i, flush_i,
    input  PCWrite_o, IF_ID_Write_o,
    input  ID_EX_RegWrite_o, ID_EX_MemtoReg_o, ID_EX_MemRead_o, ID_EX_MemWrite_o,
    input  ID_EX_ALUSrc_o, ID_EX_RegDst_o, ID_EX_Branch_o, ID_EX_ALUOp_o,
    input  ID_EX_pc_o, ID_EX_RSdata_o, ID_EX_RTdata_o, ID_EX_Imm_o,
    input  ID_EX_RSaddr_o, ID_EX_RTaddr_o, ID_EX_RDaddr_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS-subset decode stage and ID/EX pipeline register with load-use hazard
// detection, flush-driven bubbles and a saturating stall counter.
module id_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  id_ex_if.slave bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 6;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [OPW-1:0] opcode_c;
  logic [RW-1:0]  rs_c;
  logic [RW-1:0]  rt_c;
  logic [RW-1:0]  rd_c;
  ctrl_t          dec_c;
  logic           reads_rs_c;
  logic           reads_rt_c;
  logic           hazard_c;
  logic           stall_c;

  ctrl_t            ctrl_q,   ctrl_d;
  logic [XLEN-1:0]  pc_q,     pc_d;
  logic [XLEN-1:0]  rsdata_q, rsdata_d;
  logic [XLEN-1:0]  rtdata_q, rtdata_d;
  logic [XLEN-1:0]  imm_q,    imm_d;
  logic [RW-1:0]    rsaddr_q, rsaddr_d;
  logic [RW-1:0]    rtaddr_q, rtaddr_d;
  logic [RW-1:0]    rdaddr_q, rdaddr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  assign opcode_c = bus.IF_ID_inst_i[31:26];
  assign rs_c     = bus.IF_ID_inst_i[25:21];
  assign rt_c     = bus.IF_ID_inst_i[20:16];
  assign rd_c     = bus.IF_ID_inst_i[15:11];

  // Opcode decode and source-register usage of the instruction in IF/ID.
  always_comb begin
    dec_c      = '0;
    reads_rs_c = 1'b0;
    reads_rt_c = 1'b0;
    case (opcode_c)
      OP_RTYPE: begin
        dec_c.reg_write = 1'b1;
        dec_c.reg_dst   = 1'b1;
        dec_c.alu_op    = 2'b10;
        reads_rs_c      = 1'b1;
        reads_rt_c      = 1'b1;
      end
      OP_ADDI: begin
        dec_c.reg_write = 1'b1;
        dec_c.alu_src   = 1'b1;
        reads_rs_c      = 1'b1;
      end
      OP_LW: begin
        dec_c.reg_write  = 1'b1;
        dec_c.mem_to_reg = 1'b1;
        dec_c.mem_read   = 1'b1;
        dec_c.alu_src    = 1'b1;
        reads_rs_c       = 1'b1;
      end
      OP_SW: begin
        dec_c.mem_write = 1'b1;
        dec_c.alu_src   = 1'b1;
        reads_rs_c      = 1'b1;
        reads_rt_c      = 1'b1;
      end
      OP_BEQ: begin
        dec_c.branch = 1'b1;
        dec_c.alu_op = 2'b01;
        reads_rs_c   = 1'b1;
        reads_rt_c   = 1'b1;
      end
      default: begin
        dec_c = '0;
      end
    endcase
  end

  // A load in EX whose destination feeds the IF/ID instruction; $0 never hazards.
  assign hazard_c = ctrl_q.mem_read && (rtaddr_q != '0) &&
                    ((reads_rs_c && (rs_c == rtaddr_q)) ||
                     (reads_rt_c && (rt_c == rtaddr_q)));
  assign stall_c  = hazard_c && !bus.flush_i;

  assign bus.PCWrite_o     = !stall_c;
  assign bus.IF_ID_Write_o = !stall_c;

  // Next-state: data always follows the inputs, only controls are squashed.
  always_comb begin
    ctrl_d   = dec_c;
    pc_d     = bus.IF_ID_pc_i;
    rsdata_d = bus.RSdata_i;
    rtdata_d = bus.RTdata_i;
    imm_d    = bus.Imm32_i;
    rsaddr_d = rs_c;
    rtaddr_d = rt_c;
    rdaddr_d = rd_c;
    cnt_d    = cnt_q;
    if (stall_c || bus.flush_i) begin
      ctrl_d = '0;
    end
    if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q   <= '0;
      pc_q     <= '0;
      rsdata_q <= '0;
      rtdata_q <= '0;
      imm_q    <= '0;
      rsaddr_q <= '0;
      rtaddr_q <= '0;
      rdaddr_q <= '0;
      cnt_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      pc_q     <= pc_d;
      rsdata_q <= rsdata_d;
      rtdata_q <= rtdata_d;
      imm_q    <= imm_d;
      rsaddr_q <= rsaddr_d;
      rtaddr_q <= rtaddr_d;
      rdaddr_q <= rdaddr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ID_EX_RegWrite_o = ctrl_q.reg_write;
  assign bus.ID_EX_MemtoReg_o = ctrl_q.mem_to_reg;
  assign bus.ID_EX_MemRead_o  = ctrl_q.mem_read;
  assign bus.ID_EX_MemWrite_o = ctrl_q.mem_write;
  assign bus.ID_EX_ALUSrc_o   = ctrl_q.alu_src;
  assign bus.ID_EX_RegDst_o   = ctrl_q.reg_dst;
  assign bus.ID_EX_Branch_o   = ctrl_q.branch;
  assign bus.ID_EX_ALUOp_o    = ctrl_q.alu_op;
  assign bus.ID_EX_pc_o       = pc_q;
  assign bus.ID_EX_RSdata_o   = rsdata_q;
  assign bus.ID_EX_RTdata_o   = rtdata_q;
  assign bus.ID_EX_Imm_o      = imm_q;
  assign bus.ID_EX_RSaddr_o   = rsaddr_q;
  assign bus.ID_EX_RTaddr_o   = rtaddr_q;
  assign bus.ID_EX_RDaddr_o   = rdaddr_q;
  assign bus.stall_cnt_o      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction stream, two counter widths.
module tb_id_ex_stage;

  // Control vector order: RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,RegDst,Branch,ALUOp[1:0]
  localparam logic [8:0] C_LW  = 9'h1D0;
  localparam logic [8:0] C_R   = 9'h10A;
  localparam logic [8:0] C_ADI = 9'h110;
  localparam logic [8:0] C_SW  = 9'h030;
  localparam logic [8:0] C_BEQ = 9'h005;
  localparam logic [8:0] C_NOP = 9'h000;

  localparam logic [31:0] I_LW2   = 32'h8C220004; // lw   $2,4($1)
  localparam logic [31:0] I_LW0   = 32'h8C200000; // lw   $0,0($1)
  localparam logic [31:0] I_LW5   = 32'h8C250000; // lw   $5,0($1)
  localparam logic [31:0] I_ADD   = 32'h00432020; // add  $4,$2,$3
  localparam logic [31:0] I_ADD0  = 32'h00032020; // add  $4,$0,$3
  localparam logic [31:0] I_ADDI  = 32'h20C50001; // addi $5,$6,1
  localparam logic [31:0] I_SW    = 32'hAC220008; // sw   $2,8($1)
  localparam logic [31:0] I_BEQ   = 32'h10220010; // beq  $1,$2,16
  localparam logic [31:0] I_BAD   = 32'hFC000000; // unlisted opcode
  localparam logic [31:0] I_ZERO  = 32'h00000000;

  typedef struct {
    logic [8:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst, pc, rsd, rtd, imm;
  logic        flush;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   k       = 0;
  exp_t sb[$];
  exp_t me;

  id_ex_if #(.CNT_W(16)) bif ();
  id_ex_if #(.CNT_W(2))  bif2 ();

  assign bif.IF_ID_inst_i  = inst;
  assign bif.IF_ID_pc_i    = pc;
  assign bif.RSdata_i      = rsd;
  assign bif.RTdata_i      = rtd;
  assign bif.Imm32_i       = imm;
  assign bif.flush_i       = flush;
  assign bif2.IF_ID_inst_i = inst;
  assign bif2.IF_ID_pc_i   = pc;
  assign bif2.RSdata_i     = rsd;
  assign bif2.RTdata_i     = rtd;
  assign bif2.Imm32_i      = imm;
  assign bif2.flush_i      = flush;

  id_ex_stage #(.CNT_W(16)) dut  (.clk_i(clk), .rst_ni(rst_n), .bus(bif));
  id_ex_stage #(.CNT_W(2))  dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bif2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ctrl_of1();
    return {bif.ID_EX_RegWrite_o, bif.ID_EX_MemtoReg_o, bif.ID_EX_MemRead_o,
            bif.ID_EX_MemWrite_o, bif.ID_EX_ALUSrc_o, bif.ID_EX_RegDst_o,
            bif.ID_EX_Branch_o, bif.ID_EX_ALUOp_o};
  endfunction

  // Drive one IF/ID vector, check the combinational enables, queue the next-edge result.
  task automatic step(input logic [31:0] i_inst, input logic i_fl, input logic [8:0] e_ctrl,
                      input logic e_pcw, input logic [15:0] e_cnt, input logic [1:0] e_cnt2);
    exp_t e;
    @(negedge clk);
    inst  = i_inst;
    flush = i_fl;
    pc    = 32'h0040_0000 + 32'(k * 4);
    rsd   = 32'hA5A5_0000 ^ 32'(k);
    rtd   = 32'h5A5A_0000 + 32'(k * 3);
    imm   = {{16{i_inst[15]}}, i_inst[15:0]};
    k++;
    #1;
    chk("pcwrite", 64'(bif.PCWrite_o), 64'(e_pcw));
    chk("ifid_write", 64'(bif.IF_ID_Write_o), 64'(e_pcw));
    e.ctrl = e_ctrl;  e.pc = pc;  e.rsd = rsd;  e.rtd = rtd;  e.imm = imm;
    e.rs = i_inst[25:21];  e.rt = i_inst[20:16];  e.rd = i_inst[15:11];
    e.cnt = e_cnt;  e.cnt2 = e_cnt2;
    sb.push_back(e);
  endtask

  task automatic reset_check();
    chk("rst_ctrl", 64'(ctrl_of1()), 64'(C_NOP));
    chk("rst_data", {bif.ID_EX_pc_o, bif.ID_EX_RSdata_o}, 64'h0);
    chk("rst_data2", {bif.ID_EX_RTdata_o, bif.ID_EX_Imm_o}, 64'h0);
    chk("rst_addr", 64'({bif.ID_EX_RSaddr_o, bif.ID_EX_RTaddr_o, bif.ID_EX_RDaddr_o}), 64'h0);
    chk("rst_cnt", 64'(bif.stall_cnt_o), 64'h0);
    chk("rst_cnt2", 64'(bif2.stall_cnt_o), 64'h0);
    chk("rst_pcwrite", 64'(bif.PCWrite_o), 64'h1);
    chk("rst_ifid_write", 64'(bif.IF_ID_Write_o), 64'h1);
  endtask

  // Monitor: every edge with a queued expectation is compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("ctrl", 64'(ctrl_of1()), 64'(me.ctrl));
      chk("pc", 64'(bif.ID_EX_pc_o), 64'(me.pc));
      chk("rsdata", 64'(bif.ID_EX_RSdata_o), 64'(me.rsd));
      chk("rtdata", 64'(bif.ID_EX_RTdata_o), 64'(me.rtd));
      chk("imm", 64'(bif.ID_EX_Imm_o), 64'(me.imm));
      chk("addrs", 64'({bif.ID_EX_RSaddr_o, bif.ID_EX_RTaddr_o, bif.ID_EX_RDaddr_o}),
          64'({me.rs, me.rt, me.rd}));
      chk("stall_cnt", 64'(bif.stall_cnt_o), 64'(me.cnt));
      chk("stall_cnt_sat", 64'(bif2.stall_cnt_o), 64'(me.cnt2));
    end
  end

  initial begin
    rst_n = 1'b0;
    inst  = '0;  pc = '0;  rsd = '0;  rtd = '0;  imm = '0;  flush = 1'b0;
    #1;
    reset_check();
    #1 rst_n = 1'b1;

    step(I_LW2,  1'b0, C_LW,  1'b1, 16'd0, 2'd0);
    step(I_ADD,  1'b0, C_NOP, 1'b0, 16'd1, 2'd1);  // load-use bubble
    step(I_ADD,  1'b0, C_R,   1'b1, 16'd1, 2'd1);  // re-issue, no second stall
    step(I_LW0,  1'b0, C_LW,  1'b1, 16'd1, 2'd1);
    step(I_ADD0, 1'b0, C_R,   1'b1, 16'd1, 2'd1);  // $0 never hazards
    step(I_LW2,  1'b0, C_LW,  1'b1, 16'd1, 2'd1);
    step(I_ADDI, 1'b0, C_ADI, 1'b1, 16'd1, 2'd1);  // rt of addi is not read
    step(I_LW5,  1'b0, C_LW,  1'b1, 16'd1, 2'd1);
    step(I_ADDI, 1'b0, C_ADI, 1'b1, 16'd1, 2'd1);  // addi destination $5 is not a source
    step(I_LW2,  1'b0, C_LW,  1'b1, 16'd1, 2'd1);
    step(I_SW,   1'b0, C_NOP, 1'b0, 16'd2, 2'd2);  // sw reads rt
    step(I_SW,   1'b0, C_SW,  1'b1, 16'd2, 2'd2);
    step(I_LW2,  1'b0, C_LW,  1'b1, 16'd2, 2'd2);
    step(I_BEQ,  1'b1, C_NOP, 1'b1, 16'd2, 2'd2);  // flush overrides hazard, not counted
    step(I_BEQ,  1'b0, C_BEQ, 1'b1, 16'd2, 2'd2);
    step(I_BAD,  1'b0, C_NOP, 1'b1, 16'd2, 2'd2);
    step(I_ZERO, 1'b0, C_R,   1'b1, 16'd2, 2'd2);
    step(I_LW2,  1'b0, C_LW,  1'b1, 16'd2, 2'd2);
    step(I_ADD,  1'b0, C_NOP, 1'b0, 16'd3, 2'd3);
    step(I_LW2,  1'b0, C_LW,  1'b1, 16'd3, 2'd3);
    step(I_ADD,  1'b0, C_NOP, 1'b0, 16'd4, 2'd3);  // narrow counter saturates
    step(I_LW2,  1'b0, C_LW,  1'b1, 16'd4, 2'd3);
    step(I_ADD,  1'b0, C_NOP, 1'b0, 16'd5, 2'd3);
    step(I_LW2,  1'b0, C_LW,  1'b1, 16'd5, 2'd3);

    // Mid-stall asynchronous reset with live registers.
    @(negedge clk);
    inst = I_ADD;
    #1;
    chk("stall_pcwrite", 64'(bif.PCWrite_o), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    reset_check();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(I_LW2,  1'b0, C_LW,  1'b1, 16'd0, 2'd0);  // first edge after reset captures
    step(I_ADD,  1'b0, C_NOP, 1'b0, 16'd1, 2'd1);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
